writeback_mux_buf: RTL

Parametrised write-back source selector with a 2-entry output buffer for the CPU datapath. Selects one of `NUM_SRC` data sources (ALU, data memory, PC+4, immediate, …) by priority, tags it with destination register and write enable, and holds it in a small FIFO with valid/ready handshake so a stalled register-file write port does not lose results. Sits between execute/memory and the register-file write port. It is the multi-source, buffered successor to the 3-input write-back mux.

---
 rtl/writeback_mux_buf.sv | 123 ++++++++++++
 1 files changed

// File: rtl/writeback_mux_buf.sv
// Write-back source selector with a 2-entry valid/ready output buffer.
// Picks the highest-indexed selected source, tags it with rd/write-enable and queues it.
module writeback_mux_buf #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] entradas,
  input  logic [NUM_SRC-1:0]            selecao,
  input  logic [REG_ADDR_WIDTH-1:0]     rd_in,
  input  logic                          escreve_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_WIDTH-1:0]         saida,
  output logic [REG_ADDR_WIDTH-1:0]     rd_out,
  output logic                          escreve_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          conflito,
  output logic [CNT_WIDTH-1:0]          conflito_cnt
);

  localparam int unsigned EntW = DATA_WIDTH + REG_ADDR_WIDTH + 1;

  // Head entry drives the outputs directly; tail holds the second queued beat.
  logic [EntW-1:0]      head_q, head_d;
  logic [EntW-1:0]      tail_q, tail_d;
  logic [1:0]           occ_q, occ_d;
  logic                 conflito_q, conflito_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] sel_data;
  logic                  multi_sel;
  logic                  we_eff;
  logic [EntW-1:0]       new_ent;
  logic                  push;
  logic                  pop;

  // Ascending scan so the highest set index overrides lower ones.
  always_comb begin
    sel_data = entradas[DATA_WIDTH-1:0];
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (selecao[k]) begin
        sel_data = entradas[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // More than one bit set iff clearing the lowest set bit leaves something.
  assign multi_sel = (selecao & (selecao - NUM_SRC'(1))) != '0;
  assign we_eff    = escreve_in && (rd_in != '0);
  assign new_ent   = {sel_data, rd_in, we_eff};

  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    conflito_d = conflito_q;
    cnt_d      = cnt_q;

    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_d = new_ent;
        end else begin
          tail_d = new_ent;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        // Popping the last entry leaves the head untouched so outputs hold.
        if (occ_q == 2'd2) begin
          head_d = tail_q;
        end
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // Push implies occupancy < 2 and pop implies > 0, so exactly one entry.
        head_d = new_ent;
      end
      default: begin
      end
    endcase

    if (push && multi_sel) begin
      conflito_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= 2'd0;
      conflito_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      conflito_q <= conflito_d;
      cnt_q      <= cnt_d;
    end
  end

  assign saida        = head_q[EntW-1 -: DATA_WIDTH];
  assign rd_out       = head_q[REG_ADDR_WIDTH:1];
  assign escreve_out  = head_q[0];
  assign conflito     = conflito_q;
  assign conflito_cnt = cnt_q;

endmodule
